pio_poll_master: RTL and testbench

Avalon-MM master that polls a single-bit input PIO slave's data register at a fixed period and turns the sampled bit into a debounced level, single-cycle rise/fall pulses and a wrapping edge counter. It is the initiator for the team's 1-bit input PIO slaves, whose `readdata` is registered: read latency is fixed at 1 cycle and there is no waitrequest. It sits between such a PIO slave and fabric logic that needs edge events without a Nios II software polling loop.

---
 rtl/pio_poll_pkg.sv | 15 +
 rtl/pio_poll_master_debounce.sv | 49 ++++
 rtl/pio_poll_master.sv | 114 +++++++++++
 tb/tb_pio_poll_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_poll_pkg.sv
// pio_poll_pkg: shared types and constants for the polled PIO master.
// Holds the poll FSM encoding, the PIO data address and edge counter width.
package pio_poll_pkg;

   typedef enum logic [1:0] {
      WAIT,
      REQ,
      LAT,
      CAPTURE
   } poll_state_t;

   localparam int PIO_DATA_ADDR = 0;
   localparam int EDGE_CNT_W    = 16;

endpackage

// File: rtl/pio_poll_master_debounce.sv
// pio_debounce: run-length debounce of a polled 1-bit sample stream,
// producing a stable level plus one-cycle rise/fall pulses.
module pio_debounce #(
   parameter int STABLE_SAMPLES = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic samp,
   input  logic sample_valid,
   output logic level,
   output logic rise,
   output logic fall
);

   logic       cand;
   logic [3:0] run;
   logic       level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand <= 1'b0;
         run  <= 4'd0;
      end else if (sample_valid) begin
         if (samp != cand) begin
            cand <= samp;
            run  <= 4'd1;
         end else if (run != 4'hF) begin
            run <= run + 4'd1;
         end
      end
   end

   // Level follows the candidate only once it has been seen enough times.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level   <= 1'b0;
         level_q <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         if (run >= 4'(STABLE_SAMPLES) && cand != level)
            level <= cand;
         level_q <= level;
         rise    <= level & ~level_q;
         fall    <= ~level & level_q;
      end
   end

endmodule

// File: rtl/pio_poll_master.sv
// pio_poll_master: Avalon-MM master that periodically reads a 1-bit PIO
// and turns the samples into a debounced level, edge pulses and a count.
module pio_poll_master
   import pio_poll_pkg::*;
#(
   parameter int POLL_PERIOD    = 1000,
   parameter int READ_LATENCY   = 1,
   parameter int STABLE_SAMPLES = 3,
   parameter int ADDR_W         = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   output logic [ADDR_W-1:0]     avm_address,
   output logic                  avm_read,
   input  logic                  avm_waitrequest,
   input  logic [31:0]           avm_readdata,
   output logic                  level,
   output logic                  rise_pulse,
   output logic                  fall_pulse,
   output logic [EDGE_CNT_W-1:0] edge_count,
   output logic                  sample_valid
);

   localparam int PCNT_W = $clog2(POLL_PERIOD);
   localparam logic [PCNT_W-1:0] PCNT_TERM = PCNT_W'(POLL_PERIOD - 1);
   localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

   poll_state_t       state;
   poll_state_t       state_nxt;
   logic [PCNT_W-1:0] pcnt;
   logic [1:0]        lat_cnt;
   logic              pcnt_term;
   logic              samp;
   logic              level_d;
   logic              unused_rd;

   assign pcnt_term   = (pcnt == PCNT_TERM);
   assign unused_rd   = ^avm_readdata[31:1];
   assign avm_address = ADDR_W'(PIO_DATA_ADDR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= WAIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT:    if (pcnt_term && enable) state_nxt = REQ;
         REQ:     if (!avm_waitrequest) state_nxt = LAT;
         LAT:     if (lat_cnt == 2'd0) state_nxt = CAPTURE;
         CAPTURE: state_nxt = WAIT;
         default: state_nxt = WAIT;
      endcase
   end

   always_comb begin
      avm_read     = 1'b0;
      sample_valid = 1'b0;
      unique case (state)
         REQ:     avm_read = 1'b1;
         CAPTURE: sample_valid = 1'b1;
         default: ;
      endcase
   end

   // Period counter free-runs through the read so issues stay P apart;
   // it parks at terminal count until the FSM can issue again.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt    <= '0;
         lat_cnt <= 2'd0;
         samp    <= 1'b0;
      end else begin
         if (!pcnt_term)
            pcnt <= pcnt + PCNT_W'(1);
         else if (state == WAIT && enable)
            pcnt <= '0;
         if (state == REQ && !avm_waitrequest)
            lat_cnt <= LAT_INIT;
         else if (state == LAT && lat_cnt != 2'd0)
            lat_cnt <= lat_cnt - 2'd1;
         if (state == LAT && lat_cnt == 2'd0)
            samp <= avm_readdata[0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_d    <= 1'b0;
         edge_count <= '0;
      end else begin
         level_d <= level;
         if (level != level_d)
            edge_count <= edge_count + EDGE_CNT_W'(1);
      end
   end

   pio_debounce #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
   ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .samp        (samp),
      .sample_valid(sample_valid),
      .level       (level),
      .rise        (rise_pulse),
      .fall        (fall_pulse)
   );

endmodule

// File: tb/tb_pio_poll_master.sv
// tb_pio_poll_master: directed bench with a transaction-level model of
// poll timing and sample-history debounce, checked every cycle.
module tb_pio_poll_master;

   localparam int P  = 4;
   localparam int L  = 1;
   localparam int S  = 3;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic          avm_waitrequest;
   logic [31:0]   avm_readdata = '0;
   logic          level;
   logic          rise_pulse;
   logic          fall_pulse;
   logic [15:0]   edge_count;
   logic          sample_valid;
   logic          pin;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pio_poll_master #(
      .POLL_PERIOD   (P),
      .READ_LATENCY  (L),
      .STABLE_SAMPLES(S),
      .ADDR_W        (AW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .level          (level),
      .rise_pulse     (rise_pulse),
      .fall_pulse     (fall_pulse),
      .edge_count     (edge_count),
      .sample_valid   (sample_valid)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered PIO slave: bit 0 is the pin only in the valid data cycle.
   always @(posedge clk) begin
      if (avm_read && !avm_waitrequest)
         avm_readdata <= {31'($urandom), pin};
      else
         avm_readdata <= {31'($urandom), ~pin};
   end

   // Model: n counts edges since reset release; events are scheduled by edge.
   int   n, last_iss, free_at, samp_due, lvl_due, pulse_due;
   bit   m_read, m_sv, m_level, m_rise, m_fall, pend, lvl_v, pulse_up;
   logic [15:0] m_cnt;
   bit   hist[$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n = 0; last_iss = -1; free_at = 0;
         samp_due = -1; lvl_due = -1; pulse_due = -1;
         m_read = 0; m_sv = 0; m_level = 0;
         m_rise = 0; m_fall = 0; m_cnt = '0;
         hist.delete();
      end else begin
         m_sv = 0; m_rise = 0; m_fall = 0;
         if (m_read) begin
            if (!avm_waitrequest) begin
               m_read   = 0;
               pend     = pin;
               samp_due = n + L;
               free_at  = n + L + 2;
            end
         end else if (enable && n >= free_at && n >= last_iss + P) begin
            m_read   = 1;
            last_iss = n;
         end
         if (n == pulse_due) begin
            if (pulse_up) m_rise = 1;
            else          m_fall = 1;
            m_cnt = m_cnt + 16'd1;
         end
         if (n == lvl_due) begin
            m_level   = lvl_v;
            pulse_due = n + 1;
            pulse_up  = lvl_v;
         end
         if (n == samp_due) begin
            bit same;
            m_sv = 1;
            hist.push_back(pend);
            same = (hist.size() >= S);
            for (int i = 0; i < S && same; i++)
               if (hist[hist.size() - 1 - i] != pend) same = 0;
            if (same && pend != m_level) begin
               lvl_due = n + 2;
               lvl_v   = pend;
            end
         end
         n++;
      end
   end

   always @(negedge clk) begin
      chk("read",  32'(avm_read),     32'(m_read));
      chk("addr",  32'(avm_address),  32'd0);
      chk("svld",  32'(sample_valid), 32'(m_sv));
      chk("level", 32'(level),        32'(m_level));
      chk("rise",  32'(rise_pulse),   32'(m_rise));
      chk("fall",  32'(fall_pulse),   32'(m_fall));
      chk("count", 32'(edge_count),   32'(m_cnt));
   end

   int rise_seen = 0;
   int fall_seen = 0;
   always @(negedge clk) begin
      if (rise_pulse) rise_seen++;
      if (fall_pulse) fall_seen++;
   end

   task automatic do_reset();
      @(negedge clk); #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic wait_read(input string name);
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = avm_read;
      end
      if (!got) chk(name, 32'(got), 32'd1);
   endtask

   task automatic hold_pin(input bit v, input int cyc);
      @(negedge clk); pin = v;
      repeat (cyc - 1) @(negedge clk);
   endtask

   logic [11:0] rmask, smask;
   int rd_cnt, sv_cnt, extra_rd;
   bit got;

   initial begin
      reset_n = 1'b0; enable = 1'b0;
      avm_waitrequest = 1'b0; pin = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;

      rd_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (avm_read) rd_cnt++;
      end
      chk("idle_reads", 32'(rd_cnt), 32'd0);
      chk("idle_count", 32'(edge_count), 32'd0);

      enable = 1'b1;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         rmask[k] = avm_read;
         smask[k] = sample_valid;
      end
      chk("read_edges", 32'(rmask), 32'h888);
      chk("svld_edges", 32'(smask), 32'h220);

      hold_pin(1'b1, 24);
      chk("deb_level1", 32'(level), 32'd1);
      chk("deb_count1", 32'(edge_count), 32'd1);
      chk("rise_once",  32'(rise_seen), 32'd1);

      hold_pin(1'b0, P); hold_pin(1'b1, P);
      hold_pin(1'b0, P); hold_pin(1'b1, 3 * P);
      chk("glitch_level", 32'(level), 32'd1);
      chk("glitch_count", 32'(edge_count), 32'd1);

      hold_pin(1'b0, 24);
      chk("fall_level", 32'(level), 32'd0);
      chk("fall_count", 32'(edge_count), 32'd2);
      chk("fall_once",  32'(fall_seen), 32'd1);

      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = sample_valid;
      end
      if (!got) chk("stall_sync", 32'(got), 32'd1);
      avm_waitrequest = 1'b1;
      wait_read("stall_read");
      enable = 1'b0;
      rd_cnt = 1;
      repeat (5) begin
         @(negedge clk);
         if (avm_read) rd_cnt++;
      end
      avm_waitrequest = 1'b0;
      sv_cnt = 0; extra_rd = 0;
      repeat (12) begin
         @(negedge clk);
         if (sample_valid) sv_cnt++;
         if (avm_read) extra_rd++;
      end
      chk("stall_rd_len", 32'(rd_cnt), 32'd6);
      chk("stall_samples", 32'(sv_cnt), 32'd1);
      chk("disabled_reads", 32'(extra_rd), 32'd0);
      enable = 1'b1;

      @(negedge clk); #1;
      force dut.edge_count = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1 release dut.edge_count;
      @(negedge clk);
      chk("preload", 32'(edge_count), 32'hFFFF);
      hold_pin(1'b1, 24);
      chk("wrap_count", 32'(edge_count), 32'd0);
      chk("wrap_level", 32'(level), 32'd1);

      wait_read("rst_read");
      #2 reset_n = 1'b0;
      #1;
      chk("rst_read_drop", 32'(avm_read), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      @(negedge clk); #2 reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         rmask[k] = avm_read;
      end
      chk("rst_read_edges", 32'(rmask[7:0]), 32'h88);
      chk("rst_level_after", 32'(level), 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
